// File: rtl/panda_lsu_bus_if.sv
// rtl/panda_lsu_bus_if.sv - LSU-side and data-bus-side signal bundle for panda_lsu_bus
interface panda_lsu_bus_if;
  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_we_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_stall_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  // Bridge view: takes LSU requests, masters the data bus
  modport master (
    input  lsu_req_i, lsu_addr_i, lsu_wdata_i, lsu_we_i,
    output lsu_rdata_o, lsu_stall_o, lsu_err_o,
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

  // Environment view: drives the LSU side and responds as the bus slave
  modport slave (
    output lsu_req_i, lsu_addr_i, lsu_wdata_i, lsu_we_i,
    input  lsu_rdata_o, lsu_stall_o, lsu_err_o,
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );
endinterface

// File: rtl/panda_lsu_bus.sv
// rtl/panda_lsu_bus.sv - single-outstanding LSU to req/gnt/rvalid data bus bridge
module panda_lsu_bus (
  input logic             clk_i,
  input logic             rst_i,
  panda_lsu_bus_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:2] addr_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; grant only matters while a request is driven
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (bus.lsu_req_i) state_d = bus.data_gnt_i ? WAIT_RVALID : WAIT_GNT;
      WAIT_GNT:    if (bus.data_gnt_i) state_d = WAIT_RVALID;
      WAIT_RVALID: if (bus.data_rvalid_i) state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Address-phase latch on IDLE requests, response capture only in WAIT_RVALID
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.lsu_req_i) begin
        addr_q  <= bus.lsu_addr_i[31:2];
        we_q    <= bus.lsu_we_i;
        wdata_q <= bus.lsu_wdata_i;
      end
      if (state_q == WAIT_RVALID && bus.data_rvalid_i) begin
        rdata_q <= bus.data_rdata_i;
        err_q   <= bus.data_err_i;
      end
    end
  end

  // Outputs: IDLE passes the LSU straight through, later states replay the latch
  always_comb begin
    bus.data_req_o   = 1'b0;
    bus.data_addr_o  = {addr_q, 2'b00};
    bus.data_we_o    = |we_q;
    bus.data_be_o    = (|we_q) ? we_q : 4'b1111;
    bus.data_wdata_o = wdata_q;
    bus.lsu_stall_o  = 1'b0;
    bus.lsu_err_o    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.data_req_o   = bus.lsu_req_i;
        bus.data_addr_o  = {bus.lsu_addr_i[31:2], 2'b00};
        bus.data_we_o    = |bus.lsu_we_i;
        bus.data_be_o    = (|bus.lsu_we_i) ? bus.lsu_we_i : 4'b1111;
        bus.data_wdata_o = bus.lsu_wdata_i;
        bus.lsu_stall_o  = bus.lsu_req_i;
      end
      WAIT_GNT: begin
        bus.data_req_o  = 1'b1;
        bus.lsu_stall_o = bus.lsu_req_i;
      end
      WAIT_RVALID: bus.lsu_stall_o = 1'b1;
      DONE:        bus.lsu_err_o   = err_q;
      default:     bus.lsu_stall_o = 1'b0;
    endcase
    if (rst_i) begin
      bus.data_req_o  = 1'b0;
      bus.lsu_stall_o = 1'b0;
      bus.lsu_err_o   = 1'b0;
    end
  end

  assign bus.lsu_rdata_o = rdata_q;

endmodule

// File: tb/tb_panda_lsu_bus.sv
// tb/tb_panda_lsu_bus.sv - directed self-checking bench for panda_lsu_bus
module tb_panda_lsu_bus;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  panda_lsu_bus_if bus ();

  panda_lsu_bus dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu(input logic req, input logic [31:0] addr, input logic [3:0] we,
                     input logic [31:0] wdata);
    bus.lsu_req_i   = req;
    bus.lsu_addr_i  = addr;
    bus.lsu_we_i    = we;
    bus.lsu_wdata_i = wdata;
  endtask

  task automatic rsp(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                     input logic err);
    bus.data_gnt_i    = gnt;
    bus.data_rvalid_i = rvalid;
    bus.data_rdata_i  = rdata;
    bus.data_err_i    = err;
    #1;
  endtask

  task automatic chk_addr_phase(input string tag, input logic [31:0] addr, input logic we,
                                input logic [3:0] be, input logic [31:0] wdata);
    chk({tag, "_req"},   32'(bus.data_req_o), 32'd1);
    chk({tag, "_addr"},  bus.data_addr_o, addr);
    chk({tag, "_we"},    32'(bus.data_we_o), 32'(we));
    chk({tag, "_be"},    32'(bus.data_be_o), 32'(be));
    chk({tag, "_wdata"}, bus.data_wdata_o, wdata);
  endtask

  initial begin
    lsu(1'b1, 32'h0000_0ABC, 4'hF, 32'h1);
    rsp(1'b1, 1'b1, 32'h9999_9999, 1'b1);
    tick(); tick();
    rsp(1'b1, 1'b1, 32'h9999_9999, 1'b1);
    chk("rst_req",   32'(bus.data_req_o), 32'd0);
    chk("rst_stall", 32'(bus.lsu_stall_o), 32'd0);
    chk("rst_err",   32'(bus.lsu_err_o), 32'd0);
    chk("rst_rdata", bus.lsu_rdata_o, 32'd0);
    rst = 1'b0;
    lsu(1'b0, 32'h0, 4'h0, 32'h0);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // zero-wait load
    lsu(1'b1, 32'h0000_0100, 4'h0, 32'h0);
    rsp(1'b1, 1'b0, 32'h0, 1'b0);
    chk_addr_phase("zw", 32'h100, 1'b0, 4'hF, 32'h0);
    chk("zw_stall0", 32'(bus.lsu_stall_o), 32'd1);
    tick();
    rsp(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("zw_req_wr", 32'(bus.data_req_o), 32'd0);
    chk("zw_stall1", 32'(bus.lsu_stall_o), 32'd1);
    tick();
    lsu(1'b0, 32'h0, 4'h0, 32'h0);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk("zw_stall2", 32'(bus.lsu_stall_o), 32'd0);
    chk("zw_rdata",  bus.lsu_rdata_o, 32'hDEAD_BEEF);
    chk("zw_err",    32'(bus.lsu_err_o), 32'd0);
    tick();

    // store with grant after 3 cycles; LSU inputs scrambled to prove the latch
    lsu(1'b1, 32'h0000_0204, 4'b0011, 32'h1234_1234);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk_addr_phase("gd0", 32'h204, 1'b1, 4'b0011, 32'h1234_1234);
    for (int i = 1; i <= 3; i++) begin
      tick();
      lsu(1'b1, 32'hFFFF_FF00 + 32'(i), 4'hC, 32'h0BAD_0000 + 32'(i));
      rsp(i == 3, 1'b0, 32'h0, 1'b0);
      chk_addr_phase($sformatf("gd%0d", i), 32'h204, 1'b1, 4'b0011, 32'h1234_1234);
      chk($sformatf("gd%0d_stall", i), 32'(bus.lsu_stall_o), 32'd1);
    end
    tick();
    rsp(1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0);
    chk("gd_req_wr",   32'(bus.data_req_o), 32'd0);
    chk("gd_stall_wr", 32'(bus.lsu_stall_o), 32'd1);
    tick();
    lsu(1'b0, 32'h0, 4'h0, 32'h0);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk("gd_rdata", bus.lsu_rdata_o, 32'hA5A5_A5A5);
    chk("gd_stall_done", 32'(bus.lsu_stall_o), 32'd0);
    tick();

    // rvalid after 5 cycles; stray gnt and rdata noise while waiting
    lsu(1'b1, 32'h0000_030B, 4'h0, 32'h0);
    rsp(1'b1, 1'b0, 32'h0, 1'b0);
    chk_addr_phase("rd", 32'h308, 1'b0, 4'hF, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      rsp(1'b1, 1'b0, 32'h1111_1111, 1'b1);
      chk($sformatf("rd%0d_req", i), 32'(bus.data_req_o), 32'd0);
      chk($sformatf("rd%0d_stall", i), 32'(bus.lsu_stall_o), 32'd1);
      chk($sformatf("rd%0d_rdata", i), bus.lsu_rdata_o, 32'hA5A5_A5A5);
    end
    tick();
    rsp(1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
    chk("rd5_stall", 32'(bus.lsu_stall_o), 32'd1);
    tick();
    lsu(1'b0, 32'h0, 4'h0, 32'h0);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rd_rdata", bus.lsu_rdata_o, 32'h5555_AAAA);
    chk("rd_stall_done", 32'(bus.lsu_stall_o), 32'd0);
    chk("rd_err", 32'(bus.lsu_err_o), 32'd0);
    tick();

    // error response, then a stray rvalid in IDLE
    lsu(1'b1, 32'h0000_040C, 4'h0, 32'h0);
    rsp(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    rsp(1'b0, 1'b1, 32'h0BAD_F00D, 1'b1);
    chk("er_err_wr", 32'(bus.lsu_err_o), 32'd0);
    tick();
    lsu(1'b0, 32'h0, 4'h0, 32'h0);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk("er_err_done", 32'(bus.lsu_err_o), 32'd1);
    chk("er_rdata", bus.lsu_rdata_o, 32'h0BAD_F00D);
    tick();
    rsp(1'b0, 1'b1, 32'h7777_7777, 1'b1);
    chk("er_err_next", 32'(bus.lsu_err_o), 32'd0);
    tick();
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk("idle_rv_rdata", bus.lsu_rdata_o, 32'h0BAD_F00D);
    chk("idle_rv_err",   32'(bus.lsu_err_o), 32'd0);
    chk("idle_rv_stall", 32'(bus.lsu_stall_o), 32'd0);

    // back-to-back load then store
    lsu(1'b1, 32'h0000_0500, 4'h0, 32'h0);
    rsp(1'b1, 1'b0, 32'h0, 1'b0);
    chk_addr_phase("bb_ld", 32'h500, 1'b0, 4'hF, 32'h0);
    tick();
    rsp(1'b0, 1'b1, 32'h0102_0304, 1'b0);
    tick();
    lsu(1'b1, 32'h0000_0504, 4'hF, 32'hCAFE_BABE);
    rsp(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bb_done_req",   32'(bus.data_req_o), 32'd0);
    chk("bb_done_stall", 32'(bus.lsu_stall_o), 32'd0);
    chk("bb_done_rdata", bus.lsu_rdata_o, 32'h0102_0304);
    tick();
    rsp(1'b1, 1'b0, 32'h0, 1'b0);
    chk_addr_phase("bb_st", 32'h504, 1'b1, 4'hF, 32'hCAFE_BABE);
    chk("bb_st_stall", 32'(bus.lsu_stall_o), 32'd1);
    tick();
    rsp(1'b0, 1'b1, 32'h0000_0000, 1'b0);
    chk("bb_st_req_wr", 32'(bus.data_req_o), 32'd0);
    tick();
    lsu(1'b0, 32'h0, 4'h0, 32'h0);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk("bb_st_rdata", bus.lsu_rdata_o, 32'h0);
    tick();
    chk("bb_no_dup_req", 32'(bus.data_req_o), 32'd0);

    // reset in WAIT_RVALID, then a late rvalid
    lsu(1'b1, 32'h0000_0600, 4'h0, 32'h0);
    rsp(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mr_rst_req",   32'(bus.data_req_o), 32'd0);
    chk("mr_rst_stall", 32'(bus.lsu_stall_o), 32'd0);
    tick();
    rst = 1'b0;
    lsu(1'b0, 32'h0, 4'h0, 32'h0);
    rsp(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("mr_stall", 32'(bus.lsu_stall_o), 32'd0);
    chk("mr_req",   32'(bus.data_req_o), 32'd0);
    tick();
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mr_rdata", bus.lsu_rdata_o, 32'h0);
    chk("mr_err",   32'(bus.lsu_err_o), 32'd0);
    chk("mr_stall2", 32'(bus.lsu_stall_o), 32'd0);
    lsu(1'b1, 32'h0000_0700, 4'h0, 32'h0);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk_addr_phase("mr_idle", 32'h700, 1'b0, 4'hF, 32'h0);
    tick();
    lsu(1'b1, 32'h0000_0800, 4'h0, 32'h0);
    rsp(1'b0, 1'b0, 32'h0, 1'b0);
    chk_addr_phase("mr_wgnt", 32'h700, 1'b0, 4'hF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/panda_lsu_bus.md
PANDA_LSU_BUS -- requirements
Module: panda_lsu_bus

Interface
REQ-001 SHALL have clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-003 SHALL have lsu_req_i  input  1  pipeline has a load/store this cycle.
REQ-004 SHALL have lsu_addr_i  input  32  byte address from load store unit.
REQ-005 SHALL have lsu_wdata_i  input  32  replicated store data from load store unit.
REQ-006 SHALL have lsu_we_i  input  4  byte write enables from load store unit; 0 means load.
REQ-007 SHALL have lsu_rdata_o  output  32  memory word returned to load store unit.
REQ-008 SHALL have lsu_stall_o  output  1  freeze pipeline; transfer not finished.
REQ-009 SHALL have lsu_err_o  output  1  bus error on finished transfer, one-cycle pulse.
REQ-010 SHALL have data_req_o  output  1  bus request.
REQ-011 SHALL have data_gnt_i  input  1  bus accepted address phase.
REQ-012 SHALL have data_addr_o  output  32  word-aligned bus address ({addr[31:2],2'b00}).
REQ-013 SHALL have data_we_o  output  1  bus write.
REQ-014 SHALL have data_be_o  output  4  bus byte enables.
REQ-015 SHALL have data_wdata_o  output  32  bus write data.
REQ-016 SHALL have data_rvalid_i  input  1  response phase valid (loads and stores).
REQ-017 SHALL have data_rdata_i  input  32  response read data.
REQ-018 SHALL have data_err_i  input  1  response error, qualified by data_rvalid_i.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID, DONE.
REQ-020 SHALL, in IDLE, drive data_req_o = lsu_req_i with address phase taken directly from lsu_* inputs (zero added latency).
REQ-021 SHALL latch addr, we, wdata into an address-phase register on every IDLE cycle with lsu_req_i=1.
REQ-022 SHALL map address phase as data_we_o = |lsu_we_i, data_be_o = lsu_we_i if store else 4'b1111, data_wdata_o = lsu_wdata_i.
REQ-023 SHALL go IDLE->WAIT_RVALID when lsu_req_i & data_gnt_i, IDLE->WAIT_GNT when lsu_req_i & !data_gnt_i, else stay IDLE.
REQ-024 SHALL, in WAIT_GNT, hold data_req_o=1 and drive address phase from the latched register, unchanged until grant; go to WAIT_RVALID on data_gnt_i.
REQ-025 SHALL, in WAIT_RVALID and DONE, drive data_req_o=0; at most one transfer outstanding.
REQ-026 SHALL, in WAIT_RVALID, on data_rvalid_i capture data_rdata_i into lsu_rdata_o register and data_err_i into error flag, then go to DONE; otherwise stay.
REQ-027 SHALL ignore data_rvalid_i in IDLE, WAIT_GNT and DONE (no capture, no state change).
REQ-028 SHALL ignore data_gnt_i when data_req_o=0.
REQ-029 SHALL assert lsu_stall_o = lsu_req_i in IDLE and WAIT_GNT, 1 in WAIT_RVALID, 0 in DONE.
REQ-030 SHALL assert lsu_err_o only in DONE, equal to the captured error flag.
REQ-031 SHALL always go DONE->IDLE after one cycle; a new lsu_req_i in the following IDLE cycle starts a new transfer.
REQ-032 SHALL hold lsu_rdata_o stable from DONE until the next captured response; stores also update it with bus rdata.
REQ-033 SHALL give minimum transfer latency of 2 cycles stall (gnt in request cycle, rvalid next cycle) then DONE with stall low.
REQ-034 SHALL not alter lsu_addr_i bits [1:0] meaning; byte lane selection remains in the load store unit.

Reset
REQ-035 SHALL, while rst_i=1, force state IDLE, data_req_o=0, lsu_stall_o=0, lsu_err_o=0, lsu_rdata_o=0, latched address phase=0.
REQ-036 SHALL, on rst_i asserted mid-transfer (WAIT_GNT or WAIT_RVALID), abandon the transfer and return to IDLE next cycle; subsequent late rvalid is ignored per REQ-027.

Verification
REQ-037 SHALL test zero-wait load: addr 0x100, we 0, gnt same cycle, rvalid next with 0xDEADBEEF -> be 4'b1111, stall 1,1,0, lsu_rdata_o=0xDEADBEEF in DONE.
REQ-038 SHALL test grant delay: store addr 0x204 we 4'b0011 wdata 0x12341234, gnt after 3 cycles -> req held 4 cycles, addr 0x204/be/wdata stable throughout, we=1.
REQ-039 SHALL test rvalid delay of 5 cycles -> stall held, req low after grant, rdata captured only on rvalid.
REQ-040 SHALL test error: rvalid with data_err_i=1 -> lsu_err_o=1 exactly one cycle in DONE, 0 next cycle.
REQ-041 SHALL test back-to-back: load then store on consecutive DONE/IDLE -> second req asserted cycle after DONE, no lost or duplicated transfer.
REQ-042 SHALL test reset in WAIT_RVALID then stray rvalid with 0xFFFFFFFF -> state IDLE, lsu_rdata_o stays 0, stall 0.
